// File: rtl/ifu_if.sv
// Fetch-side bundle: instruction memory request/response, decode handshake and execute redirect.
// The master modport is the fetch unit and the slave modport is its environment.
interface ifu_if #(
  parameter int unsigned DATA_LEN = 32
);
  logic                imem_req_valid;
  logic                imem_req_ready;
  logic [DATA_LEN-1:0] imem_addr;
  logic                imem_rsp_valid;
  logic [31:0]         imem_rsp_data;
  logic                inst_valid;
  logic                inst_ready;
  logic [31:0]         inst;
  logic [DATA_LEN-1:0] PC;
  logic [DATA_LEN-1:0] PC_S;
  logic                jump_valid;
  logic [DATA_LEN-1:0] jump_addr;

  modport master (
    output imem_req_valid, imem_addr, inst_valid, inst, PC, PC_S,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready, jump_valid, jump_addr
  );

  modport slave (
    input  imem_req_valid, imem_addr, inst_valid, inst, PC, PC_S,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready, jump_valid, jump_addr
  );
endinterface

// File: rtl/ifu.sv
// Multicycle instruction fetch unit: one word read in flight, the result is held for decode,
// and jal/jalr redirects from execute are accepted in any state.
module ifu #(
  parameter int unsigned         DATA_LEN = 32,
  parameter logic [DATA_LEN-1:0] RESET_PC = 32'h8000_0000
) (
  input logic   clk,
  input logic   rst_n,
  ifu_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [DATA_LEN-1:0] fetch_pc;
  logic [DATA_LEN-1:0] pc_q;
  logic [DATA_LEN-1:0] jump_target;
  logic [31:0]         inst_q;
  logic                flush;
  logic                req_fire;
  logic                rsp_take;

  always_comb begin
    jump_target = bus.jump_addr & ~DATA_LEN'(3);
    req_fire    = (state == REQ) && bus.imem_req_ready;
    rsp_take    = (state == WAIT) && bus.imem_rsp_valid;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = REQ;
      REQ:  if (req_fire) state_nxt = WAIT;
      // A response that coincides with a redirect or a pending flush is dropped.
      WAIT: if (rsp_take) state_nxt = (flush || bus.jump_valid) ? REQ : HOLD;
      HOLD: if (bus.jump_valid || bus.inst_ready) state_nxt = REQ;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      flush    <= 1'b0;
      inst_q   <= '0;
      pc_q     <= '0;
    end else begin
      if (bus.jump_valid)
        fetch_pc <= jump_target;
      else if ((state == HOLD) && bus.inst_ready)
        fetch_pc <= fetch_pc + DATA_LEN'(4);

      // flush marks the read already accepted by memory as belonging to the old path.
      if (rsp_take)
        flush <= 1'b0;
      else if (bus.jump_valid && (req_fire || (state == WAIT)))
        flush <= 1'b1;

      if (rsp_take && !flush && !bus.jump_valid) begin
        inst_q <= bus.imem_rsp_data;
        pc_q   <= fetch_pc;
      end
    end
  end

  always_comb begin
    bus.imem_req_valid = (state == REQ);
    bus.inst_valid     = (state == HOLD);
    bus.imem_addr      = fetch_pc;
    bus.inst           = inst_q;
    bus.PC             = pc_q;
    bus.PC_S           = pc_q + DATA_LEN'(4);
  end

endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: directed cycle table, hand-written redirect/wrap/reset sequences, and a
// randomized run against a transaction-level model with a variable-latency memory.
module tb_ifu;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  ifu_if #(.DATA_LEN(32)) bus ();

  ifu #(.DATA_LEN(32), .RESET_PC(RST_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout got running expected finished");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rst;
    logic        rr;
    logic        rv;
    logic [31:0] rd;
    logic        rdy;
    logic        jv;
    logic [31:0] ja;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
  } vec_t;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'hA5C3_0F69;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic rr, input logic rv, input logic [31:0] rd,
                       input logic rdy, input logic jv, input logic [31:0] ja);
    rst_n              = r;
    bus.imem_req_ready = rr;
    bus.imem_rsp_valid = rv;
    bus.imem_rsp_data  = rd;
    bus.inst_ready     = rdy;
    bus.jump_valid     = jv;
    bus.jump_addr      = ja;
  endtask

  task automatic step(input logic r, input logic rr, input logic rv, input logic [31:0] rd,
                      input logic rdy, input logic jv, input logic [31:0] ja);
    drive(r, rr, rv, rd, rdy, jv, ja);
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic req, input logic [31:0] addr,
                            input logic iv, input logic [31:0] ins, input logic [31:0] pc);
    logic [31:0] pcs;
    pcs = pc + 32'd4;
    chk({tag, "_req_valid"}, {31'b0, bus.imem_req_valid}, {31'b0, req});
    chk({tag, "_addr"}, bus.imem_addr, addr);
    chk({tag, "_inst_valid"}, {31'b0, bus.inst_valid}, {31'b0, iv});
    chk({tag, "_inst"}, bus.inst, ins);
    chk({tag, "_pc"}, bus.PC, pc);
    chk({tag, "_pc_s"}, bus.PC_S, pcs);
  endtask

  vec_t tbl [19];

  // Transaction-level reference state for the random run.
  logic        m_idle, m_busy, m_show, m_taint, m_req;
  logic [31:0] m_exp, m_req_addr, m_show_pc, m_show_inst;
  logic        mem_pend;
  int          mem_dly;
  logic [31:0] mem_a;
  int          consumed;

  initial begin
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);

    //         rst  rr   rv   rd            rdy  jv   ja            req  addr          iv   inst          pc
    tbl[0]  = '{1'b0,1'b0,1'b0,32'h0,       1'b0,1'b0,32'h0,        1'b0,32'h8000_0000,1'b0,32'h0,       32'h0};
    tbl[1]  = '{1'b1,1'b1,1'b0,32'h0,       1'b1,1'b0,32'h0,        1'b1,32'h8000_0000,1'b0,32'h0,       32'h0};
    tbl[2]  = '{1'b1,1'b1,1'b0,32'h0,       1'b1,1'b0,32'h0,        1'b0,32'h8000_0000,1'b0,32'h0,       32'h0};
    tbl[3]  = '{1'b1,1'b0,1'b1,32'h13,      1'b1,1'b0,32'h0,        1'b0,32'h8000_0000,1'b1,32'h13,      32'h8000_0000};
    tbl[4]  = '{1'b1,1'b0,1'b0,32'h0,       1'b1,1'b0,32'h0,        1'b1,32'h8000_0004,1'b0,32'h13,      32'h8000_0000};
    tbl[5]  = '{1'b1,1'b1,1'b0,32'h0,       1'b1,1'b0,32'h0,        1'b0,32'h8000_0004,1'b0,32'h13,      32'h8000_0000};
    tbl[6]  = '{1'b1,1'b0,1'b1,32'h93,      1'b0,1'b0,32'h0,        1'b0,32'h8000_0004,1'b1,32'h93,      32'h8000_0004};
    tbl[7]  = '{1'b1,1'b1,1'b0,32'h0,       1'b0,1'b0,32'h0,        1'b0,32'h8000_0004,1'b1,32'h93,      32'h8000_0004};
    tbl[8]  = '{1'b1,1'b1,1'b1,32'hFFFF_FFFF,1'b0,1'b0,32'h0,       1'b0,32'h8000_0004,1'b1,32'h93,      32'h8000_0004};
    tbl[9]  = '{1'b1,1'b0,1'b0,32'h0,       1'b0,1'b0,32'h0,        1'b0,32'h8000_0004,1'b1,32'h93,      32'h8000_0004};
    tbl[10] = '{1'b1,1'b1,1'b0,32'h0,       1'b0,1'b0,32'h0,        1'b0,32'h8000_0004,1'b1,32'h93,      32'h8000_0004};
    tbl[11] = '{1'b1,1'b0,1'b0,32'h0,       1'b0,1'b0,32'h0,        1'b0,32'h8000_0004,1'b1,32'h93,      32'h8000_0004};
    tbl[12] = '{1'b1,1'b0,1'b0,32'h0,       1'b1,1'b0,32'h0,        1'b1,32'h8000_0008,1'b0,32'h93,      32'h8000_0004};
    tbl[13] = '{1'b1,1'b1,1'b0,32'h0,       1'b0,1'b0,32'h0,        1'b0,32'h8000_0008,1'b0,32'h93,      32'h8000_0004};
    tbl[14] = '{1'b1,1'b0,1'b1,32'h113,     1'b0,1'b0,32'h0,        1'b0,32'h8000_0008,1'b1,32'h113,     32'h8000_0008};
    tbl[15] = '{1'b1,1'b0,1'b0,32'h0,       1'b1,1'b1,32'h8000_0203,1'b1,32'h8000_0200,1'b0,32'h113,     32'h8000_0008};
    tbl[16] = '{1'b1,1'b0,1'b0,32'h0,       1'b0,1'b0,32'h0,        1'b1,32'h8000_0200,1'b0,32'h113,     32'h8000_0008};
    tbl[17] = '{1'b1,1'b1,1'b0,32'h0,       1'b0,1'b0,32'h0,        1'b0,32'h8000_0200,1'b0,32'h113,     32'h8000_0008};
    tbl[18] = '{1'b1,1'b0,1'b1,32'h193,     1'b0,1'b0,32'h0,        1'b0,32'h8000_0200,1'b1,32'h193,     32'h8000_0200};

    @(posedge clk);
    #1;
    for (int i = 0; i < 19; i++) begin
      step(tbl[i].rst, tbl[i].rr, tbl[i].rv, tbl[i].rd, tbl[i].rdy, tbl[i].jv, tbl[i].ja);
      expect_out($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_iv,
                 tbl[i].e_inst, tbl[i].e_pc);
    end

    // Redirect while waiting: the late DEADBEEF response must never reach decode.
    step(1, 0, 0, '0, 1, 0, '0);
    expect_out("wj_req", 1, 32'h8000_0204, 0, 32'h193, 32'h8000_0200);
    step(1, 1, 0, '0, 0, 0, '0);
    expect_out("wj_acc", 0, 32'h8000_0204, 0, 32'h193, 32'h8000_0200);
    step(1, 0, 0, '0, 0, 1, 32'h8000_0100);
    expect_out("wj_jump", 0, 32'h8000_0100, 0, 32'h193, 32'h8000_0200);
    for (int i = 0; i < 2; i++) begin
      step(1, 0, 0, '0, 0, 0, '0);
      expect_out("wj_wait", 0, 32'h8000_0100, 0, 32'h193, 32'h8000_0200);
    end
    step(1, 0, 1, 32'hDEAD_BEEF, 1, 0, '0);
    expect_out("wj_drop", 1, 32'h8000_0100, 0, 32'h193, 32'h8000_0200);
    step(1, 1, 0, '0, 0, 0, '0);
    step(1, 0, 1, 32'h213, 0, 0, '0);
    expect_out("wj_new", 0, 32'h8000_0100, 1, 32'h213, 32'h8000_0100);

    // Redirect from HOLD to the top word; PC_S and the next fetch wrap to zero.
    step(1, 0, 0, '0, 0, 1, 32'hFFFF_FFFC);
    expect_out("wrap_req", 1, 32'hFFFF_FFFC, 0, 32'h213, 32'h8000_0100);
    step(1, 1, 0, '0, 0, 0, '0);
    step(1, 0, 1, 32'h0010_0073, 0, 0, '0);
    expect_out("wrap_hold", 0, 32'hFFFF_FFFC, 1, 32'h0010_0073, 32'hFFFF_FFFC);
    chk("wrap_pc_s_zero", bus.PC_S, 32'h0);
    step(1, 0, 0, '0, 1, 0, '0);
    expect_out("wrap_next", 1, 32'h0, 0, 32'h0010_0073, 32'hFFFF_FFFC);

    // Reset while waiting; the stale response shows up in IDLE and again in REQ.
    step(1, 1, 0, '0, 0, 0, '0);
    step(0, 0, 0, '0, 0, 0, '0);
    expect_out("rst_idle", 0, RST_PC, 0, 32'h0, 32'h0);
    step(1, 0, 1, 32'hBAAD_F00D, 1, 0, '0);
    expect_out("rst_req", 1, RST_PC, 0, 32'h0, 32'h0);
    step(1, 0, 1, 32'hBAAD_F00D, 1, 0, '0);
    expect_out("rst_stale", 1, RST_PC, 0, 32'h0, 32'h0);
    step(1, 1, 0, '0, 0, 0, '0);
    step(1, 0, 1, 32'h13, 0, 0, '0);
    expect_out("rst_first", 0, RST_PC, 1, 32'h13, RST_PC);

    // Randomized run against the transaction-level model.
    step(0, 0, 0, '0, 0, 0, '0);
    m_idle = 1; m_busy = 0; m_show = 0; m_taint = 0; m_exp = RST_PC;
    m_req_addr = '0; m_show_pc = '0; m_show_inst = '0;
    mem_pend = 0; mem_dly = 0; mem_a = '0; consumed = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      logic        r, rr, rv, rdy, jv, req_now;
      logic [31:0] rd, ja;
      m_req = !m_idle && !m_busy && !m_show;
      chk("rnd_req_valid", {31'b0, bus.imem_req_valid}, {31'b0, m_req});
      chk("rnd_inst_valid", {31'b0, bus.inst_valid}, {31'b0, m_show});
      if (m_req) chk("rnd_addr", bus.imem_addr, m_exp);
      if (m_show) begin
        chk("rnd_inst", bus.inst, m_show_inst);
        chk("rnd_pc", bus.PC, m_show_pc);
        chk("rnd_pc_s", bus.PC_S, m_show_pc + 32'd4);
      end

      r   = ($urandom_range(0, 399) != 0);
      rr  = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      jv  = ($urandom_range(0, 11) == 0);
      ja  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
      rd  = $urandom;
      rv  = 0;
      if (mem_pend && mem_dly == 0) begin
        rv = 1;
        rd = memf(mem_a);
      end else if (!mem_pend && $urandom_range(0, 7) == 0) begin
        rv = 1;
      end

      req_now = bus.imem_req_valid && rr && r;
      if (!r) mem_pend = 0;
      else if (mem_pend && rv) mem_pend = 0;
      else if (mem_pend) mem_dly--;
      if (req_now) begin
        mem_pend = 1;
        mem_dly  = $urandom_range(0, 3);
        mem_a    = bus.imem_addr;
      end

      if (!r) begin
        m_idle = 1; m_busy = 0; m_show = 0; m_taint = 0; m_exp = RST_PC;
      end else if (m_idle) begin
        m_idle = 0;
        if (jv) m_exp = ja & 32'hFFFF_FFFC;
      end else if (m_show) begin
        if (jv) begin
          m_show = 0;
          m_exp  = ja & 32'hFFFF_FFFC;
        end else if (rdy) begin
          m_show = 0;
          m_exp  = m_show_pc + 32'd4;
          consumed++;
        end
      end else if (m_busy) begin
        if (rv) begin
          m_busy = 0;
          if (!m_taint && !jv) begin
            m_show      = 1;
            m_show_pc   = m_req_addr;
            m_show_inst = memf(m_req_addr);
          end
          m_taint = 0;
        end else if (jv) begin
          m_taint = 1;
        end
        if (jv) m_exp = ja & 32'hFFFF_FFFC;
      end else begin
        if (rr) begin
          m_busy     = 1;
          m_req_addr = m_exp;
          m_taint    = jv;
        end
        if (jv) m_exp = ja & 32'hFFFF_FFFC;
      end

      step(r, rr, rv, rd, rdy, jv, ja);
    end
    chk("rnd_progress", {31'b0, (consumed >= 100)}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
